// File: rtl/pipe_ctrl_unit_pkg.sv
// Opcode constants, control encodings and the decoded control bundle shared by the
// pipelined control unit and its decoder.
package pipe_ctrl_unit_pkg;

  localparam logic [5:0] OpNop   = 6'd0;
  localparam logic [5:0] OpAdd   = 6'd1;
  localparam logic [5:0] OpSub   = 6'd2;
  localparam logic [5:0] OpAnd   = 6'd3;
  localparam logic [5:0] OpOr    = 6'd4;
  localparam logic [5:0] OpXor   = 6'd5;
  localparam logic [5:0] OpNot   = 6'd6;
  localparam logic [5:0] OpSge   = 6'd7;
  localparam logic [5:0] OpSgt   = 6'd8;
  localparam logic [5:0] OpSle   = 6'd9;
  localparam logic [5:0] OpSlt   = 6'd10;
  localparam logic [5:0] OpSeq   = 6'd11;
  localparam logic [5:0] OpSne   = 6'd12;
  localparam logic [5:0] OpAddf  = 6'd13;
  localparam logic [5:0] OpMulf  = 6'd14;
  localparam logic [5:0] OpAddi  = 6'd16;
  localparam logic [5:0] OpSubi  = 6'd17;
  localparam logic [5:0] OpMovei = 6'd18;
  localparam logic [5:0] OpLoad  = 6'd20;
  localparam logic [5:0] OpStore = 6'd21;
  localparam logic [5:0] OpMove  = 6'd22;
  localparam logic [5:0] OpSli   = 6'd24;
  localparam logic [5:0] OpSri   = 6'd25;
  localparam logic [5:0] OpJump  = 6'd28;
  localparam logic [5:0] OpBra   = 6'd29;

  localparam logic [1:0] MtrAlu  = 2'b00;
  localparam logic [1:0] MtrMem  = 2'b01;
  localparam logic [1:0] MtrMove = 2'b10;

  localparam logic [1:0] JbNone = 2'b00;
  localparam logic [1:0] JbBra  = 2'b01;
  localparam logic [1:0] JbJump = 2'b10;

  localparam logic [1:0] FwdNone = 2'b00;
  localparam logic [1:0] FwdMem  = 2'b01;
  localparam logic [1:0] FwdWb   = 2'b10;

  typedef enum logic {DestRd, DestRt} dest_sel_e;

  typedef struct packed {
    logic       rf_write;
    logic       dm_write;
    dest_sel_e  dest_sel;
    logic [1:0] mem_to_reg;
    logic [1:0] jump_or_branch;
    logic       sli_sri;
    logic       imm_instr;
    logic       uses_rs;
    logic       uses_rt;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode decoder: ID-stage opcode to control bundle. Anything not
// recognised (including NOP and id_valid low) yields an all-zero bundle with legal low.
module pipe_ctrl_decode
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int unsigned OPC_W = 6
) (
  input  logic             valid,
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl,
  output logic             legal
);

  always_comb begin
    ctrl  = '0;
    legal = 1'b0;
    if (valid) begin
      legal = 1'b1;
      case (opcode)
        OPC_W'(OpAdd), OPC_W'(OpSub), OPC_W'(OpAnd), OPC_W'(OpOr), OPC_W'(OpXor),
        OPC_W'(OpNot), OPC_W'(OpSge), OPC_W'(OpSgt), OPC_W'(OpSle), OPC_W'(OpSlt),
        OPC_W'(OpSeq), OPC_W'(OpSne), OPC_W'(OpAddf), OPC_W'(OpMulf): begin
          ctrl.rf_write = 1'b1;
          ctrl.uses_rs  = 1'b1;
          ctrl.uses_rt  = 1'b1;
        end
        OPC_W'(OpAddi), OPC_W'(OpSubi): begin
          ctrl.rf_write  = 1'b1;
          ctrl.imm_instr = 1'b1;
          ctrl.uses_rs   = 1'b1;
        end
        OPC_W'(OpMovei): begin
          ctrl.rf_write  = 1'b1;
          ctrl.imm_instr = 1'b1;
        end
        OPC_W'(OpLoad): begin
          ctrl.rf_write   = 1'b1;
          ctrl.dest_sel   = DestRt;
          ctrl.mem_to_reg = MtrMem;
          ctrl.uses_rs    = 1'b1;
        end
        OPC_W'(OpStore): begin
          ctrl.dm_write = 1'b1;
          ctrl.uses_rs  = 1'b1;
          ctrl.uses_rt  = 1'b1;
        end
        OPC_W'(OpMove): begin
          ctrl.rf_write   = 1'b1;
          ctrl.dest_sel   = DestRt;
          ctrl.mem_to_reg = MtrMove;
          ctrl.uses_rs    = 1'b1;
        end
        OPC_W'(OpSli), OPC_W'(OpSri): begin
          ctrl.rf_write = 1'b1;
          ctrl.dest_sel = DestRt;
          ctrl.sli_sri  = 1'b1;
          ctrl.uses_rs  = 1'b1;
        end
        OPC_W'(OpJump): ctrl.jump_or_branch = JbJump;
        OPC_W'(OpBra): begin
          ctrl.jump_or_branch = JbBra;
          ctrl.uses_rs        = 1'b1;
        end
        default: legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes ID, carries controls through ID/EX, EX/MEM, MEM/WB and
// resolves hazards. Define PIPE_CTRL_FWD_EN to enable operand forwarding (load-use stall only).
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int unsigned OPC_W    = 6,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned MULF_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             ex_branch_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             ex_valid,
  output logic             ex_imm_instr,
  output logic             ex_sli_sri,
  output logic [1:0]       ex_jump_or_branch,
  output logic [OPC_W-1:0] ex_opcode,
  output logic             mem_dm_write,
  output logic             wb_rf_write,
  output logic [1:0]       wb_mem_to_reg,
  output logic [RA_W-1:0]  wb_dest,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel
);

  localparam logic [3:0] MulfLoad = 4'(MULF_LAT - 1);

  ctrl_t            id_ctrl;
  logic             id_legal;
  logic             id_is_mulf;
  logic [RA_W-1:0]  id_dest;

  logic             ex_valid_q, ex_rf_write_q, ex_dm_write_q, ex_sli_sri_q, ex_imm_q;
  logic [1:0]       ex_mem_to_reg_q, ex_jb_q;
  logic [OPC_W-1:0] ex_opcode_q;
  logic [RA_W-1:0]  ex_dest_q;

  logic             mem_rf_write_q, mem_dm_write_q;
  logic [1:0]       mem_mem_to_reg_q;
  logic [RA_W-1:0]  mem_dest_q;

  logic             wb_rf_write_q;
  logic [1:0]       wb_mem_to_reg_q;
  logic [RA_W-1:0]  wb_dest_q;

  logic [3:0]       mulf_cnt_q;

  logic branch_flush, mulf_busy, mulf_hold, raw_stall, id_hit_ex, ex_bubble, ex_load;

  pipe_ctrl_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .valid  (id_valid),
    .opcode (id_opcode),
    .ctrl   (id_ctrl),
    .legal  (id_legal)
  );

  assign id_dest    = !id_ctrl.rf_write        ? '0    :
                      (id_ctrl.dest_sel == DestRt) ? id_rt : id_rd;
  assign id_is_mulf = id_legal && (id_opcode == OPC_W'(OpMulf));

  assign branch_flush = ex_valid_q && (ex_jb_q == JbBra) && ex_branch_taken;
  assign mulf_busy    = (mulf_cnt_q != 4'd0);
  assign id_hit_ex    = (id_ctrl.uses_rs && (id_rs == ex_dest_q)) ||
                        (id_ctrl.uses_rt && (id_rt == ex_dest_q));

`ifdef PIPE_CTRL_FWD_EN
  logic            ex_use_rs_q, ex_use_rt_q;
  logic [RA_W-1:0] ex_rs_q, ex_rt_q;

  // Only a load in EX cannot be satisfied by forwarding.
  assign raw_stall = ex_valid_q && ex_rf_write_q && (ex_mem_to_reg_q == MtrMem) && id_hit_ex;

  always_comb begin
    fwd_a_sel = FwdNone;
    fwd_b_sel = FwdNone;
    if (ex_use_rs_q) begin
      if (mem_rf_write_q && (mem_dest_q == ex_rs_q))     fwd_a_sel = FwdMem;
      else if (wb_rf_write_q && (wb_dest_q == ex_rs_q))  fwd_a_sel = FwdWb;
    end
    if (ex_use_rt_q) begin
      if (mem_rf_write_q && (mem_dest_q == ex_rt_q))     fwd_b_sel = FwdMem;
      else if (wb_rf_write_q && (wb_dest_q == ex_rt_q))  fwd_b_sel = FwdWb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || ex_bubble) begin
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
    end else if (ex_load) begin
      ex_use_rs_q <= id_ctrl.uses_rs;
      ex_use_rt_q <= id_ctrl.uses_rt;
      ex_rs_q     <= id_rs;
      ex_rt_q     <= id_rt;
    end
  end
`else
  logic id_hit_mem;

  // Register file is write-through, so a writer already in WB never blocks ID.
  assign id_hit_mem = (id_ctrl.uses_rs && (id_rs == mem_dest_q)) ||
                      (id_ctrl.uses_rt && (id_rt == mem_dest_q));
  assign raw_stall  = (ex_valid_q && ex_rf_write_q && id_hit_ex) ||
                      (mem_rf_write_q && id_hit_mem);
  assign fwd_a_sel  = FwdNone;
  assign fwd_b_sel  = FwdNone;
`endif

  assign mulf_hold = mulf_busy && !branch_flush;
  assign ex_bubble = branch_flush || (!mulf_busy && raw_stall);
  assign ex_load   = !ex_bubble && !mulf_hold;

  // Priority: branch flush > MULF busy > RAW stall > jump flush.
  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    if (!reset) begin
      if (branch_flush) begin
        ifid_flush = 1'b1;
      end else if (mulf_busy || raw_stall) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
      end else if (id_ctrl.jump_or_branch == JbJump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q       <= 1'b0;
      ex_rf_write_q    <= 1'b0;
      ex_dm_write_q    <= 1'b0;
      ex_sli_sri_q     <= 1'b0;
      ex_imm_q         <= 1'b0;
      ex_mem_to_reg_q  <= MtrAlu;
      ex_jb_q          <= JbNone;
      ex_opcode_q      <= '0;
      ex_dest_q        <= '0;
      mem_rf_write_q   <= 1'b0;
      mem_dm_write_q   <= 1'b0;
      mem_mem_to_reg_q <= MtrAlu;
      mem_dest_q       <= '0;
      wb_rf_write_q    <= 1'b0;
      wb_mem_to_reg_q  <= MtrAlu;
      wb_dest_q        <= '0;
      mulf_cnt_q       <= 4'd0;
    end else begin
      wb_rf_write_q   <= mem_rf_write_q;
      wb_mem_to_reg_q <= mem_mem_to_reg_q;
      wb_dest_q       <= mem_dest_q;

      if (mulf_hold) begin
        mem_rf_write_q   <= 1'b0;
        mem_dm_write_q   <= 1'b0;
        mem_mem_to_reg_q <= MtrAlu;
        mem_dest_q       <= '0;
        mulf_cnt_q       <= mulf_cnt_q - 4'd1;
      end else begin
        mem_rf_write_q   <= ex_rf_write_q;
        mem_dm_write_q   <= ex_dm_write_q;
        mem_mem_to_reg_q <= ex_mem_to_reg_q;
        mem_dest_q       <= ex_dest_q;
        mulf_cnt_q       <= (ex_load && id_is_mulf) ? MulfLoad : 4'd0;
      end

      if (ex_bubble) begin
        ex_valid_q      <= 1'b0;
        ex_rf_write_q   <= 1'b0;
        ex_dm_write_q   <= 1'b0;
        ex_sli_sri_q    <= 1'b0;
        ex_imm_q        <= 1'b0;
        ex_mem_to_reg_q <= MtrAlu;
        ex_jb_q         <= JbNone;
        ex_opcode_q     <= '0;
        ex_dest_q       <= '0;
      end else if (ex_load) begin
        ex_valid_q      <= id_legal;
        ex_rf_write_q   <= id_ctrl.rf_write;
        ex_dm_write_q   <= id_ctrl.dm_write;
        ex_sli_sri_q    <= id_ctrl.sli_sri;
        ex_imm_q        <= id_ctrl.imm_instr;
        ex_mem_to_reg_q <= id_ctrl.mem_to_reg;
        ex_jb_q         <= id_ctrl.jump_or_branch;
        ex_opcode_q     <= id_legal ? id_opcode : '0;
        ex_dest_q       <= id_dest;
      end
    end
  end

  assign ex_valid          = ex_valid_q;
  assign ex_imm_instr      = ex_imm_q;
  assign ex_sli_sri        = ex_sli_sri_q;
  assign ex_jump_or_branch = ex_jb_q;
  assign ex_opcode         = ex_opcode_q;
  assign mem_dm_write      = mem_dm_write_q;
  assign wb_rf_write       = wb_rf_write_q;
  assign wb_mem_to_reg     = wb_mem_to_reg_q;
  assign wb_dest           = wb_dest_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit (MULF_LAT = 4); expectations follow
// PIPE_CTRL_FWD_EN when it is defined for the build.
module tb_pipe_ctrl_unit;
  import pipe_ctrl_unit_pkg::*;

  localparam int unsigned OPC_W    = 6;
  localparam int unsigned RA_W     = 5;
  localparam int unsigned MULF_LAT = 4;
`ifdef PIPE_CTRL_FWD_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             id_valid = 1'b0;
  logic [OPC_W-1:0] id_opcode = '0;
  logic [RA_W-1:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic             ex_branch_taken = 1'b0;
  logic             pc_stall, ifid_stall, ifid_flush;
  logic             ex_valid, ex_imm_instr, ex_sli_sri;
  logic [1:0]       ex_jump_or_branch;
  logic [OPC_W-1:0] ex_opcode;
  logic             mem_dm_write, wb_rf_write;
  logic [1:0]       wb_mem_to_reg;
  logic [RA_W-1:0]  wb_dest;
  logic [1:0]       fwd_a_sel, fwd_b_sel;

  int checks = 0;
  int failures = 0;

  pipe_ctrl_unit #(
    .OPC_W    (OPC_W),
    .RA_W     (RA_W),
    .MULF_LAT (MULF_LAT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .id_valid          (id_valid),
    .id_opcode         (id_opcode),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_rd             (id_rd),
    .ex_branch_taken   (ex_branch_taken),
    .pc_stall          (pc_stall),
    .ifid_stall        (ifid_stall),
    .ifid_flush        (ifid_flush),
    .ex_valid          (ex_valid),
    .ex_imm_instr      (ex_imm_instr),
    .ex_sli_sri        (ex_sli_sri),
    .ex_jump_or_branch (ex_jump_or_branch),
    .ex_opcode         (ex_opcode),
    .mem_dm_write      (mem_dm_write),
    .wb_rf_write       (wb_rf_write),
    .wb_mem_to_reg     (wb_mem_to_reg),
    .wb_dest           (wb_dest),
    .fwd_a_sel         (fwd_a_sel),
    .fwd_b_sel         (fwd_b_sel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd);
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, OpNop, 5'd0, 5'd0, 5'd0);
    repeat (n) step();
  endtask

  task automatic test_reset();
    logic [26:0] outs;
    reset = 1'b1;
    drive(1'b1, OpAdd, 5'd1, 5'd2, 5'd3);
    step();
    outs = {pc_stall, ifid_stall, ifid_flush, ex_valid, ex_imm_instr, ex_sli_sri,
            ex_jump_or_branch, ex_opcode, mem_dm_write, wb_rf_write, wb_mem_to_reg,
            wb_dest, fwd_a_sel, fwd_b_sel};
    checks++;
    if (outs !== 27'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    reset = 1'b0;
    #1;
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_opcode !== OpAdd) begin
      failures++; $display("FAIL reset_add_ex got=%b/%0d exp=1/%0d", ex_valid, ex_opcode, OpAdd);
    end
    drive(1'b0, OpNop, 5'd0, 5'd0, 5'd0);
    step();
    step();
    checks++;
    if (wb_rf_write !== 1'b1 || wb_dest !== 5'd3 || wb_mem_to_reg !== MtrAlu) begin
      failures++;
      $display("FAIL reset_add_wb got=%b/%0d/%b exp=1/3/00", wb_rf_write, wb_dest, wb_mem_to_reg);
    end
  endtask

  task automatic test_load_use();
    int stalls = 0;
    logic mismatch = 1'b0;
    idle(3);
    drive(1'b1, OpLoad, 5'd1, 5'd2, 5'd0);
    step();
    drive(1'b1, OpAdd, 5'd2, 5'd1, 5'd4);
    for (int i = 0; i < 6; i++) begin
      if (!pc_stall) break;
      if (ifid_stall !== pc_stall) mismatch = 1'b1;
      stalls++;
      step();
    end
    checks++;
    if (stalls != (FwdOn ? 1 : 2)) begin
      failures++; $display("FAIL load_use_stalls got=%0d exp=%0d", stalls, FwdOn ? 1 : 2);
    end
    checks++;
    if (mismatch) begin
      failures++; $display("FAIL load_use_ifid_stall got=differs exp=equal_to_pc_stall");
    end
    step();
    drive(1'b0, OpNop, 5'd0, 5'd0, 5'd0);
    checks++;
    if (ex_valid !== 1'b1 || ex_opcode !== OpAdd) begin
      failures++; $display("FAIL load_use_add_ex got=%b/%0d exp=1/%0d", ex_valid, ex_opcode, OpAdd);
    end
    checks++;
    if (fwd_a_sel !== (FwdOn ? FwdWb : FwdNone) || fwd_b_sel !== FwdNone) begin
      failures++;
      $display("FAIL load_use_fwd got=%b/%b exp=%b/00", fwd_a_sel, fwd_b_sel,
               FwdOn ? FwdWb : FwdNone);
    end
  endtask

  task automatic test_branch();
    idle(3);
    drive(1'b1, OpAdd, 5'd20, 5'd21, 5'd8);
    step();
    drive(1'b1, OpBra, 5'd5, 5'd0, 5'd0);
    step();
    checks++;
    if (ex_jump_or_branch !== JbBra) begin
      failures++; $display("FAIL branch_ex_jb got=%b exp=01", ex_jump_or_branch);
    end
    ex_branch_taken = 1'b1;
    drive(1'b1, OpSub, 5'd8, 5'd9, 5'd7);
    checks++;
    if (ifid_flush !== 1'b1 || pc_stall !== 1'b0 || ifid_stall !== 1'b0) begin
      failures++;
      $display("FAIL branch_flush got=%b/%b/%b exp=1/0/0", ifid_flush, pc_stall, ifid_stall);
    end
    step();
    ex_branch_taken = 1'b0;
    drive(1'b0, OpNop, 5'd0, 5'd0, 5'd0);
    checks++;
    if (ex_valid !== 1'b0 || ex_opcode !== '0) begin
      failures++; $display("FAIL branch_ex_bubble got=%b/%0d exp=0/0", ex_valid, ex_opcode);
    end
    checks++;
    if (wb_rf_write !== 1'b1 || wb_dest !== 5'd8) begin
      failures++; $display("FAIL branch_prior_add_wb got=%b/%0d exp=1/8", wb_rf_write, wb_dest);
    end
    step();
    step();
    checks++;
    if (wb_rf_write !== 1'b0) begin
      failures++; $display("FAIL branch_sub_discarded got=%b exp=0", wb_rf_write);
    end
  endtask

  task automatic test_mulf();
    int stalls = 0;
    logic held = 1'b1;
    idle(3);
    drive(1'b1, OpMulf, 5'd1, 5'd2, 5'd6);
    step();
    drive(1'b1, OpAdd, 5'd11, 5'd12, 5'd10);
    for (int i = 0; i < 10; i++) begin
      if (!pc_stall) break;
      if (ex_opcode !== OpMulf || wb_rf_write !== 1'b0) held = 1'b0;
      stalls++;
      step();
    end
    checks++;
    if (stalls != MULF_LAT - 1) begin
      failures++; $display("FAIL mulf_stalls got=%0d exp=%0d", stalls, MULF_LAT - 1);
    end
    checks++;
    if (!held) begin
      failures++; $display("FAIL mulf_hold got=not_held exp=mulf_in_ex_and_bubbles_behind");
    end
    step();
    drive(1'b0, OpNop, 5'd0, 5'd0, 5'd0);
    checks++;
    if (ex_opcode !== OpAdd || wb_rf_write !== 1'b0) begin
      failures++;
      $display("FAIL mulf_add_ex got=%0d/%b exp=%0d/0", ex_opcode, wb_rf_write, OpAdd);
    end
    step();
    checks++;
    if (wb_rf_write !== 1'b1 || wb_dest !== 5'd6) begin
      failures++; $display("FAIL mulf_wb got=%b/%0d exp=1/6", wb_rf_write, wb_dest);
    end
    step();
    checks++;
    if (wb_rf_write !== 1'b1 || wb_dest !== 5'd10) begin
      failures++; $display("FAIL mulf_next_wb got=%b/%0d exp=1/10", wb_rf_write, wb_dest);
    end
    // Reset in the middle of a MULF occupancy must clear the counter.
    idle(3);
    drive(1'b1, OpMulf, 5'd1, 5'd2, 5'd6);
    step();
    drive(1'b0, OpNop, 5'd0, 5'd0, 5'd0);
    step();
    checks++;
    if (pc_stall !== 1'b1) begin
      failures++; $display("FAIL mulf_mid_stall got=%b exp=1", pc_stall);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (pc_stall !== 1'b0 || ex_valid !== 1'b0) begin
      failures++; $display("FAIL mulf_reset_clear got=%b/%b exp=0/0", pc_stall, ex_valid);
    end
  endtask

  task automatic test_jump();
    logic saw_dm = 1'b0;
    logic saw_rf = 1'b0;
    idle(3);
    drive(1'b1, OpJump, 5'd0, 5'd0, 5'd0);
    checks++;
    if (ifid_flush !== 1'b1 || pc_stall !== 1'b0) begin
      failures++; $display("FAIL jump_flush got=%b/%b exp=1/0", ifid_flush, pc_stall);
    end
    step();
    // The delay-slot STORE has been cleared to a NOP in IF/ID.
    drive(1'b0, OpStore, 5'd1, 5'd2, 5'd0);
    checks++;
    if (ex_valid !== 1'b1 || ex_jump_or_branch !== JbJump || ifid_flush !== 1'b0) begin
      failures++;
      $display("FAIL jump_ex got=%b/%b/%b exp=1/10/0", ex_valid, ex_jump_or_branch, ifid_flush);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_dm_write) saw_dm = 1'b1;
      if (wb_rf_write) saw_rf = 1'b1;
    end
    checks++;
    if (saw_dm || saw_rf) begin
      failures++; $display("FAIL jump_no_writes got=%b/%b exp=0/0", saw_dm, saw_rf);
    end
    drive(1'b1, OpStore, 5'd1, 5'd2, 5'd0);
    step();
    drive(1'b0, OpNop, 5'd0, 5'd0, 5'd0);
    step();
    checks++;
    if (mem_dm_write !== 1'b1) begin
      failures++; $display("FAIL store_mem_write got=%b exp=1", mem_dm_write);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [5:0] op   [N] = '{OpAddi, OpSli, OpMove, OpLoad, OpMovei, 6'h3F};
    logic [4:0] rs   [N] = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd1, 5'd24};
    logic [4:0] rt   [N] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd25, 5'd26};
    logic [4:0] rd   [N] = '{5'd1, 5'd9, 5'd9, 5'd9, 5'd5, 5'd7};
    logic       e_v  [N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       e_im [N] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       e_sl [N] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       e_wr [N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] e_mr [N] = '{MtrAlu, MtrAlu, MtrMove, MtrMem, MtrAlu, MtrAlu};
    logic [4:0] e_ds [N] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd0};
    idle(3);
    for (int j = 0; j < N + 2; j++) begin
      if (j < N) drive(1'b1, op[j], rs[j], rt[j], rd[j]);
      else drive(1'b0, OpNop, 5'd0, 5'd0, 5'd0);
      checks++;
      if (pc_stall !== 1'b0) begin
        failures++; $display("FAIL b2b_no_stall[%0d] got=%b exp=0", j, pc_stall);
      end
      step();
      if (j < N) begin
        checks++;
        if (ex_valid !== e_v[j] || ex_imm_instr !== e_im[j] || ex_sli_sri !== e_sl[j]) begin
          failures++;
          $display("FAIL b2b_ex[%0d] got=%b/%b/%b exp=%b/%b/%b", j, ex_valid, ex_imm_instr,
                   ex_sli_sri, e_v[j], e_im[j], e_sl[j]);
        end
      end
      if (j >= 2) begin
        checks++;
        if (wb_rf_write !== e_wr[j-2] || wb_mem_to_reg !== e_mr[j-2] ||
            wb_dest !== e_ds[j-2]) begin
          failures++;
          $display("FAIL b2b_wb[%0d] got=%b/%b/%0d exp=%b/%b/%0d", j - 2, wb_rf_write,
                   wb_mem_to_reg, wb_dest, e_wr[j-2], e_mr[j-2], e_ds[j-2]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mulf();
    test_jump();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
